layer6_pixel_buffer: RTL and testbench

LAYER6_PIXEL_BUFFER -- requirements
Module: layer6_pixel_buffer

---
 rtl/layer6_pixel_buffer.sv | 154 +++++++++++++++
 tb/tb_layer6_pixel_buffer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/layer6_pixel_buffer.sv
// Frame buffer for one IN_DIM x IN_DIM feature map with 2x2 pooling-window reads.
// Latency: a write is stored on the edge it is presented; window data appears one cycle after read_pixel_signal.
// Backpressure: none; writes while FULL are dropped and flagged on sticky wr_overflow.
// Optional feature: define LAYER6_PIXEL_BUFFER_RANGE_CHECK_EN to zero out-of-range window
// pixels and reject out-of-range writes. Without it, indices wrap modulo IN_DIM.
module layer6_pixel_buffer #(
   parameter int IN_DIM    = 16,
   parameter int PIX_WIDTH = 128
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [15:0]          wr_row,
   input  logic [15:0]          wr_col,
   input  logic [PIX_WIDTH-1:0] wr_data,
   input  logic                 read_pixel_signal,
   input  logic [15:0]          read_row_addr,
   input  logic [15:0]          read_col_addr,
   output logic [PIX_WIDTH-1:0] input_data_even_even,
   output logic [PIX_WIDTH-1:0] input_data_even_odd,
   output logic [PIX_WIDTH-1:0] input_data_odd_even,
   output logic [PIX_WIDTH-1:0] input_data_odd_odd,
   output logic                 pixel_store_done,
   input  logic                 layer6_calculation_done,
   output logic                 wr_overflow
);

   localparam int          AW    = $clog2(IN_DIM);
   localparam logic [15:0] TOTAL = 16'(IN_DIM * IN_DIM);
   localparam logic [16:0] DIM17 = 17'(IN_DIM);

   typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [15:0]            cnt_q, cnt_d;
   logic                   done_q, done_d;
   logic                   ovf_q, ovf_d;
   logic                   mem_we;
   logic                   wr_in_range;
   logic [PIX_WIDTH-1:0]   mem_q [IN_DIM][IN_DIM];

   logic [16:0]            r0, r1, c0, c1;
   logic                   ok_r0, ok_r1, ok_c0, ok_c1;
   logic [PIX_WIDTH-1:0]   ee_q, ee_d, eo_q, eo_d, oe_q, oe_d, oo_q, oo_d;

   // Upper address bits are only consulted by the range-checked build.
   logic                   unused_bits;
   assign unused_bits = ^{r0, r1, c0, c1, wr_row, wr_col};

   // Write acceptance, fill counting and FILL/FULL next-state decision.
   always_comb begin
`ifdef LAYER6_PIXEL_BUFFER_RANGE_CHECK_EN
      wr_in_range = ({1'b0, wr_row} < DIM17) && ({1'b0, wr_col} < DIM17);
`else
      wr_in_range = 1'b1;
`endif
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      ovf_d   = ovf_q;
      mem_we  = 1'b0;
      case (state_q)
         FILL: begin
            // completion is decided purely by count, rewrites of an address still count
            if (wr_en) begin
               if (wr_in_range) begin
                  mem_we = 1'b1;
                  cnt_d  = cnt_q + 16'd1;
                  if (cnt_d == TOTAL) begin
                     state_d = FULL;
                     done_d  = 1'b1;
                  end
               end else begin
                  ovf_d = 1'b1;
               end
            end
         end
         FULL: begin
            // a write in the re-arm cycle still belongs to the full frame and is rejected
            if (wr_en) ovf_d = 1'b1;
            if (layer6_calculation_done) begin
               state_d = FILL;
               cnt_d   = 16'd0;
            end
         end
         default: state_d = FILL;
      endcase
   end

   // 2x2 window index generation at 17 bits and output capture/hold.
   always_comb begin
      r0 = {read_row_addr, 1'b0};
      r1 = {read_row_addr, 1'b1};
      c0 = {read_col_addr, 1'b0};
      c1 = {read_col_addr, 1'b1};
`ifdef LAYER6_PIXEL_BUFFER_RANGE_CHECK_EN
      ok_r0 = r0 < DIM17;
      ok_r1 = r1 < DIM17;
      ok_c0 = c0 < DIM17;
      ok_c1 = c1 < DIM17;
`else
      ok_r0 = 1'b1;
      ok_r1 = 1'b1;
      ok_c0 = 1'b1;
      ok_c1 = 1'b1;
`endif
      ee_d = ee_q;
      eo_d = eo_q;
      oe_d = oe_q;
      oo_d = oo_q;
      if (read_pixel_signal) begin
         ee_d = (ok_r0 && ok_c0) ? mem_q[r0[AW-1:0]][c0[AW-1:0]] : '0;
         eo_d = (ok_r0 && ok_c1) ? mem_q[r0[AW-1:0]][c1[AW-1:0]] : '0;
         oe_d = (ok_r1 && ok_c0) ? mem_q[r1[AW-1:0]][c0[AW-1:0]] : '0;
         oo_d = (ok_r1 && ok_c1) ? mem_q[r1[AW-1:0]][c1[AW-1:0]] : '0;
      end
   end

   // Pixel storage; not reset, and a same-cycle read sees the pre-write value.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) mem_q[wr_row[AW-1:0]][wr_col[AW-1:0]] <= wr_data;
   end

   // Control state and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FILL;
         cnt_q   <= 16'd0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         ee_q    <= '0;
         eo_q    <= '0;
         oe_q    <= '0;
         oo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         ee_q    <= ee_d;
         eo_q    <= eo_d;
         oe_q    <= oe_d;
         oo_q    <= oo_d;
      end
   end

   assign pixel_store_done     = done_q;
   assign wr_overflow          = ovf_q;
   assign input_data_even_even = ee_q;
   assign input_data_even_odd  = eo_q;
   assign input_data_odd_even  = oe_q;
   assign input_data_odd_odd   = oo_q;

endmodule

// File: tb/tb_layer6_pixel_buffer.sv
// Directed bench for layer6_pixel_buffer (IN_DIM=16, PIX_WIDTH=128).
// Inputs change on the falling edge; outputs are sampled on the falling edge after the active edge.
// Expected pixel values are row*16+col plus a per-frame base, replicated in all eight channels.
module tb_layer6_pixel_buffer;
   localparam int IN_DIM = 16;
   localparam int PW     = 128;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [15:0]   wr_row, wr_col;
   logic [PW-1:0] wr_data;
   logic          read_pixel_signal;
   logic [15:0]   read_row_addr, read_col_addr;
   logic [PW-1:0] ee, eo, oe, oo;
   logic          pixel_store_done;
   logic          layer6_calculation_done;
   logic          wr_overflow;

   int errs   = 0;
   int checks = 0;
   logic [PW-1:0] model [IN_DIM][IN_DIM];

   always #5 clk = ~clk;

   layer6_pixel_buffer #(.IN_DIM(IN_DIM), .PIX_WIDTH(PW)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .wr_en                   (wr_en),
      .wr_row                  (wr_row),
      .wr_col                  (wr_col),
      .wr_data                 (wr_data),
      .read_pixel_signal       (read_pixel_signal),
      .read_row_addr           (read_row_addr),
      .read_col_addr           (read_col_addr),
      .input_data_even_even    (ee),
      .input_data_even_odd     (eo),
      .input_data_odd_even     (oe),
      .input_data_odd_odd      (oo),
      .pixel_store_done        (pixel_store_done),
      .layer6_calculation_done (layer6_calculation_done),
      .wr_overflow             (wr_overflow)
   );

   task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] rep(input int v);
      logic [15:0] s;
      s = 16'(v);
      return {8{s}};
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input int r, input int c, input logic [PW-1:0] d, input bit acc);
      wr_en   = 1'b1;
      wr_row  = 16'(r);
      wr_col  = 16'(c);
      wr_data = d;
      tick();
      wr_en = 1'b0;
      if (acc) model[r % IN_DIM][c % IN_DIM] = d;
   endtask

   task automatic rd(input int r, input int c);
      read_pixel_signal = 1'b1;
      read_row_addr     = 16'(r);
      read_col_addr     = 16'(c);
      tick();
      read_pixel_signal = 1'b0;
   endtask

   function automatic logic [PW-1:0] exp_pix(input int row, input int col);
`ifdef LAYER6_PIXEL_BUFFER_RANGE_CHECK_EN
      if (row >= IN_DIM || col >= IN_DIM) return '0;
`endif
      return model[row % IN_DIM][col % IN_DIM];
   endfunction

   task automatic check_win(input string tag, input int r, input int c);
      chk({tag, "_ee"}, ee, exp_pix(2*r,   2*c));
      chk({tag, "_eo"}, eo, exp_pix(2*r,   2*c+1));
      chk({tag, "_oe"}, oe, exp_pix(2*r+1, 2*c));
      chk({tag, "_oo"}, oo, exp_pix(2*r+1, 2*c+1));
   endtask

   // Raster writes from index start to 255; done must stay low until after the last one.
   task automatic fill(input string tag, input int base, input int start);
      logic early;
      early = 1'b0;
      for (int i = start; i < IN_DIM*IN_DIM; i++) begin
         wr(i / IN_DIM, i % IN_DIM, rep(base + i), 1'b1);
         if (i < IN_DIM*IN_DIM - 1) early = early | pixel_store_done;
      end
      chk({tag, "_early_done"}, PW'(early), PW'(0));
      chk({tag, "_done"}, PW'(pixel_store_done), PW'(1));
      tick();
      chk({tag, "_done_1cyc"}, PW'(pixel_store_done), PW'(0));
   endtask

   initial begin
      logic [PW-1:0] old00;
      rst = 1'b1; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
      read_pixel_signal = 1'b0; read_row_addr = '0; read_col_addr = '0;
      layer6_calculation_done = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_ee", ee, '0);
      chk("rst_oo", oo, '0);
      chk("rst_done", PW'(pixel_store_done), PW'(0));
      chk("rst_ovf", PW'(wr_overflow), PW'(0));

      // first raster fill and window read (r=3,c=5 -> rows 6/7, cols 10/11)
      fill("fill1", 0, 0);
      rd(3, 5);
      chk("win35_ee", ee, rep(16'h6A));
      chk("win35_oo", oo, rep(16'h7B));
      check_win("win35", 3, 5);

      // re-arm with a simultaneous write: write rejected and flagged
      layer6_calculation_done = 1'b1;
      wr(0, 1, rep(16'hDEAD), 1'b0);
      layer6_calculation_done = 1'b0;
      chk("rearm_ovf", PW'(wr_overflow), PW'(1));
      rd(0, 0);
      check_win("rearm_keep", 0, 0);

      // second fill after re-arm, then a FULL write must not touch storage
      fill("fill2", 16'h100, 0);
      rd(3, 5);
      check_win("win35b", 3, 5);
      wr(6, 10, rep(16'hBEEF), 1'b0);
      rd(3, 5);
      check_win("full_wr", 3, 5);
      chk("full_ovf", PW'(wr_overflow), PW'(1));

      // hold: no read, writes continue, outputs stay put
      for (int k = 0; k < 10; k++) begin
         wr(k, k, rep(16'hF00D), 1'b0);
         check_win("hold", 3, 5);
      end

      // reset: outputs and flags clear, storage survives
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst2_ee", ee, '0);
      chk("rst2_ovf", PW'(wr_overflow), PW'(0));
      rd(3, 5);
      check_win("rst_keep", 3, 5);

      // reset mid-fill abandons 100 writes
      for (int i = 0; i < 100; i++) wr(i / IN_DIM, i % IN_DIM, rep(16'h300 + i), 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // same-cycle read and write of [0][0] returns the old value; this is write #1
      old00 = model[0][0];
      read_pixel_signal = 1'b1;
      read_row_addr = 16'd0;
      read_col_addr = 16'd0;
      wr(0, 0, rep(16'h200), 1'b1);
      read_pixel_signal = 1'b0;
      chk("rw_old", ee, old00);

      // consumer-done during FILL is ignored
      layer6_calculation_done = 1'b1;
      tick();
      layer6_calculation_done = 1'b0;
      chk("fill_ignore_done", PW'(pixel_store_done), PW'(0));
      fill("fill3", 16'h200, 1);
      rd(0, 0);
      check_win("win00c", 0, 0);

      // out-of-range window row r=8 -> rows 16/17
      rd(8, 0);
      check_win("range", 8, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
